// File: rtl/ex_muldiv_seq.sv
// ex_muldiv_seq: iterative RV32M multiply/divide sequencer for the EX stage.
// Operands are latched when an M-op enters EX. The unit then runs a shift-add
// multiplier or a restoring divider for DATA_W cycles and stalls the upstream
// pipeline while it does. A one-cycle done_o pulse carries the result to the
// EX/MEM register, and a flush aborts the operation without a done_o.
// Optional feature macro: EX_MULDIV_PAIR_CACHE_EN. When it is defined, the
// full result of the last normal operation is kept, so the companion op
// (DIV/REM, MULH/MUL, ...) on the same operands completes in one cycle.
module ex_muldiv_seq #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start_i,
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] rs1_i,
    input  logic [DATA_W-1:0] rs2_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] result_o
);

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam logic [DATA_W-1:0]   ZERO_W   = {DATA_W{1'b0}};
    localparam logic [DATA_W-1:0]   ONE_W    = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0]   ALL_ONES = {DATA_W{1'b1}};
    localparam logic [DATA_W-1:0]   MIN_NEG  = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [2*DATA_W-1:0] ONE_DW   = {{(2*DATA_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]    CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Conditional two's-complement negation, single width.
    function automatic logic [DATA_W-1:0] neg_w(input logic [DATA_W-1:0] v, input logic en);
        return en ? (~v + ONE_W) : v;
    endfunction

    // Conditional two's-complement negation, double width (full product).
    function automatic logic [2*DATA_W-1:0] neg_dw(input logic [2*DATA_W-1:0] v, input logic en);
        return en ? (~v + ONE_DW) : v;
    endfunction

    state_t              state_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [2:0]          op_r;
    logic [2*DATA_W-1:0] acc_r;     // mul: {product_hi, multiplier}; div: {remainder, quotient}
    logic [DATA_W-1:0]   opb_r;     // multiplicand or divisor magnitude
    logic                neg_hi_r;  // negate product / remainder
    logic                neg_lo_r;  // negate quotient
    logic                done_r;
    logic [DATA_W-1:0]   result_r;

    logic                sign1_s;
    logic                sign2_s;
    logic [DATA_W-1:0]   mag1_s;
    logic [DATA_W-1:0]   mag2_s;
    logic                div_zero_s;
    logic                ovf_s;
    logic [DATA_W-1:0]   special_res_s;
    logic                neg_hi_s;
    logic                neg_lo_s;
    logic                accept_s;
    logic                calc_last_s;

    logic [DATA_W:0]     mul_sum_s;
    logic [DATA_W:0]     div_shift_s;
    logic [DATA_W:0]     div_diff_s;
    logic [2*DATA_W-1:0] acc_step_s;
    logic [2*DATA_W-1:0] prod_fin_s;
    logic [DATA_W-1:0]   quo_fin_s;
    logic [DATA_W-1:0]   rem_fin_s;
    logic [DATA_W-1:0]   calc_res_s;

    logic                cache_hit_s;
    logic [DATA_W-1:0]   cache_res_s;

    assign accept_s    = (state_r == ST_IDLE) && start_i && !flush_i;
    assign calc_last_s = (cnt_r == CNT_LAST);

    assign stall_o  = accept_s || (state_r == ST_CALC);
    assign busy_o   = (state_r != ST_IDLE);
    assign done_o   = done_r;
    assign result_o = result_r;

    // Decode the incoming op: operand signs, magnitudes and special-case results.
    always_comb begin
        sign1_s = 1'b0;
        sign2_s = 1'b0;
        case (op_i)
            // MUL is treated as signed x signed so its full product matches MULH.
            OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
                sign1_s = rs1_i[DATA_W-1];
                sign2_s = rs2_i[DATA_W-1];
            end
            OP_MULHSU: begin
                sign1_s = rs1_i[DATA_W-1];
                sign2_s = 1'b0;
            end
            default: begin
                sign1_s = 1'b0;
                sign2_s = 1'b0;
            end
        endcase
        mag1_s     = neg_w(rs1_i, sign1_s);
        mag2_s     = neg_w(rs2_i, sign2_s);
        neg_lo_s   = sign1_s ^ sign2_s;
        neg_hi_s   = op_i[2] ? sign1_s : (sign1_s ^ sign2_s);
        div_zero_s = op_i[2] && (rs2_i == ZERO_W);
        ovf_s      = ((op_i == OP_DIV) || (op_i == OP_REM)) &&
                     (rs1_i == MIN_NEG) && (rs2_i == ALL_ONES);
        if (div_zero_s) begin
            special_res_s = op_i[1] ? rs1_i : ALL_ONES;
        end else if (ovf_s) begin
            special_res_s = op_i[1] ? ZERO_W : MIN_NEG;
        end else begin
            special_res_s = ZERO_W;
        end
    end

    // One shift-add or restoring-divide step, plus sign fix-up and result select.
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[2*DATA_W-1:DATA_W]} +
                      (acc_r[0] ? {1'b0, opb_r} : {1'b0, ZERO_W});
        div_shift_s = acc_r[2*DATA_W-1:DATA_W-1];
        div_diff_s  = div_shift_s - {1'b0, opb_r};
        if (op_r[2]) begin
            if (div_diff_s[DATA_W]) begin
                acc_step_s = {div_shift_s[DATA_W-1:0], acc_r[DATA_W-2:0], 1'b0};
            end else begin
                acc_step_s = {div_diff_s[DATA_W-1:0], acc_r[DATA_W-2:0], 1'b1};
            end
        end else begin
            acc_step_s = {mul_sum_s, acc_r[DATA_W-1:1]};
        end
        prod_fin_s = neg_dw(acc_step_s, neg_hi_r);
        quo_fin_s  = neg_w(acc_step_s[DATA_W-1:0], neg_lo_r);
        rem_fin_s  = neg_w(acc_step_s[2*DATA_W-1:DATA_W], neg_hi_r);
        case (op_r)
            OP_MUL:                        calc_res_s = prod_fin_s[DATA_W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  calc_res_s = prod_fin_s[2*DATA_W-1:DATA_W];
            OP_DIV, OP_DIVU:               calc_res_s = quo_fin_s;
            OP_REM, OP_REMU:               calc_res_s = rem_fin_s;
            default:                       calc_res_s = ZERO_W;
        endcase
    end

`ifdef EX_MULDIV_PAIR_CACHE_EN
    logic                cache_vld_r;
    logic [DATA_W-1:0]   cache_rs1_r;
    logic [DATA_W-1:0]   cache_rs2_r;
    logic [2:0]          cache_cls_r;
    logic [2*DATA_W-1:0] cache_data_r;  // full product, or {remainder, quotient}

    // Ops sharing a class share one full result (MUL rides with MULH).
    function automatic logic [2:0] op_class(input logic [2:0] op);
        case (op)
            OP_MUL, OP_MULH: return 3'd0;
            OP_MULHSU:       return 3'd1;
            OP_MULHU:        return 3'd2;
            OP_DIV, OP_REM:  return 3'd4;
            OP_DIVU, OP_REMU: return 3'd5;
            default:         return 3'd7;
        endcase
    endfunction

    // Look up the incoming op and pick the low or high half of the stored result.
    always_comb begin
        cache_hit_s = cache_vld_r && (rs1_i == cache_rs1_r) && (rs2_i == cache_rs2_r) &&
                      (op_class(op_i) == cache_cls_r);
        if ((op_i == OP_MUL) || (op_i[2] && !op_i[1])) begin
            cache_res_s = cache_data_r[DATA_W-1:0];
        end else begin
            cache_res_s = cache_data_r[2*DATA_W-1:DATA_W];
        end
    end

    // Capture the tag at issue and the full result on normal completion.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cache_vld_r  <= 1'b0;
            cache_rs1_r  <= ZERO_W;
            cache_rs2_r  <= ZERO_W;
            cache_cls_r  <= 3'd0;
            cache_data_r <= {2*DATA_W{1'b0}};
        end else if (accept_s && !div_zero_s && !ovf_s && !cache_hit_s) begin
            cache_vld_r <= 1'b0;
            cache_rs1_r <= rs1_i;
            cache_rs2_r <= rs2_i;
            cache_cls_r <= op_class(op_i);
        end else if ((state_r == ST_CALC) && flush_i) begin
            cache_vld_r <= 1'b0;
        end else if ((state_r == ST_CALC) && calc_last_s) begin
            cache_vld_r  <= 1'b1;
            cache_data_r <= op_r[2] ? {rem_fin_s, quo_fin_s} : prod_fin_s;
        end
    end
`else
    assign cache_hit_s = 1'b0;
    assign cache_res_s = ZERO_W;
`endif

    // Sequencer FSM: operand latch, iteration, completion pulse, flush abort.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            op_r     <= 3'd0;
            acc_r    <= {2*DATA_W{1'b0}};
            opb_r    <= ZERO_W;
            neg_hi_r <= 1'b0;
            neg_lo_r <= 1'b0;
            done_r   <= 1'b0;
            result_r <= ZERO_W;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        op_r     <= op_i;
                        cnt_r    <= {CNT_W{1'b0}};
                        acc_r    <= {ZERO_W, mag1_s};
                        opb_r    <= mag2_s;
                        neg_hi_r <= neg_hi_s;
                        neg_lo_r <= neg_lo_s;
                        if (div_zero_s || ovf_s) begin
                            result_r <= special_res_s;
                            done_r   <= 1'b1;
                            state_r  <= ST_DONE;
                        end else if (cache_hit_s) begin
                            result_r <= cache_res_s;
                            done_r   <= 1'b1;
                            state_r  <= ST_DONE;
                        end else begin
                            state_r <= ST_CALC;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    if (flush_i) begin
                        state_r <= ST_IDLE;
                    end else begin
                        acc_r <= acc_step_s;
                        cnt_r <= cnt_r + CNT_ONE;
                        if (calc_last_s) begin
                            result_r <= calc_res_s;
                            done_r   <= 1'b1;
                            state_r  <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    // The op leaves EX this cycle; a start seen here is the same op.
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Directed testbench for ex_muldiv_seq with hand-computed expected values.
module tb_ex_muldiv_seq;

`ifdef EX_MULDIV_PAIR_CACHE_EN
    localparam int PAIR_LAT = 1;
`else
    localparam int PAIR_LAT = 33;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic        flush_i;
    logic        stall_o;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;

    int n_cmp = 0;
    int n_err = 0;

    ex_muldiv_seq #(.DATA_W(32), .CNT_W(6)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start_i  (start_i),
        .op_i     (op_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .flush_i  (flush_i),
        .stall_o  (stall_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op in the current cycle and follow it to its done pulse.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] res, output int stall_cnt,
                          output logic stall_done, output logic done_after);
        start_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b;
        #1;
        stall_cnt = (stall_o === 1'b1) ? 1 : 0;
        tick();
        start_i = 1'b0; rs1_i = 32'hDEADBEEF; rs2_i = 32'h0000_0003; op_i = 3'd5;
        #1;
        lat = 1;
        while (done_o !== 1'b1 && lat < 100) begin
            if (stall_o === 1'b1) stall_cnt++;
            tick();
            lat++;
        end
        res = result_o;
        stall_done = stall_o;
        tick();
        done_after = done_o;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start_i = 1'b0; flush_i = 1'b0; op_i = 3'd0; rs1_i = 32'd0; rs2_i = 32'd0;
        tick(); tick(); tick();
        n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done_o); end
        n_cmp++; if (result_o !== 32'd0) begin n_err++; $display("FAIL reset_result: got %h want 0", result_o); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_mulhu();
        int lat; int sc; logic [31:0] res; logic sd; logic da;
        run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, res, sc, sd, da);
        n_cmp++; if (res !== 32'hFFFFFFFE) begin n_err++; $display("FAIL mulhu_result: got %h want fffffffe", res); end
        n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL mulhu_latency: got %0d want 33", lat); end
        n_cmp++; if (sc !== 33) begin n_err++; $display("FAIL mulhu_stall_cycles: got %0d want 33", sc); end
        n_cmp++; if (sd !== 1'b0) begin n_err++; $display("FAIL mulhu_stall_in_done: got %b want 0", sd); end
        n_cmp++; if (da !== 1'b0) begin n_err++; $display("FAIL mulhu_done_width: got %b want 0", da); end
    endtask

    task automatic test_mul_signed();
        logic [2:0]  ops [8] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2};
        logic [31:0] as  [8] = '{32'hFFFFFFFD, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                 32'h80000000, 32'h12345678, 32'h80000000, 32'h80000000};
        logic [31:0] bs  [8] = '{32'h00000005, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                 32'h00000004, 32'h00000010, 32'h80000000, 32'h00000002};
        logic [31:0] ex  [8] = '{32'hFFFFFFF1, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF,
                                 32'h00000002, 32'h23456780, 32'h40000000, 32'hFFFFFFFF};
        int lat; int sc; logic [31:0] res; logic sd; logic da;
        for (int i = 0; i < 8; i++) begin
            run_op(ops[i], as[i], bs[i], lat, res, sc, sd, da);
            n_cmp++; if (res !== ex[i]) begin n_err++; $display("FAIL mul_vec%0d_result: got %h want %h", i, res, ex[i]); end
            n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL mul_vec%0d_latency: got %0d want 33", i, lat); end
        end
    endtask

    task automatic test_div();
        logic [2:0]  ops [8] = '{3'd4, 3'd6, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6};
        logic [31:0] as  [8] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'h00000007, 32'h00000007,
                                 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9};
        logic [31:0] bs  [8] = '{32'h00000002, 32'h00000002, 32'hFFFFFFFE, 32'hFFFFFFFE,
                                 32'h00000010, 32'h00000010, 32'hFFFFFFFE, 32'hFFFFFFFE};
        logic [31:0] ex  [8] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'h00000001,
                                 32'h0FFFFFFF, 32'h0000000F, 32'h00000003, 32'hFFFFFFFF};
        int          el  [8] = '{33, PAIR_LAT, 33, PAIR_LAT, 33, PAIR_LAT, 33, PAIR_LAT};
        int lat; int sc; logic [31:0] res; logic sd; logic da;
        for (int i = 0; i < 8; i++) begin
            run_op(ops[i], as[i], bs[i], lat, res, sc, sd, da);
            n_cmp++; if (res !== ex[i]) begin n_err++; $display("FAIL div_vec%0d_result: got %h want %h", i, res, ex[i]); end
            n_cmp++; if (lat !== el[i]) begin n_err++; $display("FAIL div_vec%0d_latency: got %0d want %0d", i, lat, el[i]); end
        end
    endtask

    task automatic test_div_special();
        logic [2:0]  ops [6] = '{3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6};
        logic [31:0] as  [6] = '{32'h00001234, 32'h00001234, 32'h80000000, 32'h80000000,
                                 32'hFFFFFFFB, 32'hFFFFFFFB};
        logic [31:0] bs  [6] = '{32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                 32'h00000000, 32'h00000000};
        logic [31:0] ex  [6] = '{32'hFFFFFFFF, 32'h00001234, 32'h80000000, 32'h00000000,
                                 32'hFFFFFFFF, 32'hFFFFFFFB};
        int lat; int sc; logic [31:0] res; logic sd; logic da;
        for (int i = 0; i < 6; i++) begin
            run_op(ops[i], as[i], bs[i], lat, res, sc, sd, da);
            n_cmp++; if (res !== ex[i]) begin n_err++; $display("FAIL special_vec%0d_result: got %h want %h", i, res, ex[i]); end
            n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL special_vec%0d_latency: got %0d want 1", i, lat); end
            n_cmp++; if (sc !== 1) begin n_err++; $display("FAIL special_vec%0d_stall_cycles: got %0d want 1", i, sc); end
            n_cmp++; if (da !== 1'b0) begin n_err++; $display("FAIL special_vec%0d_done_width: got %b want 0", i, da); end
        end
    endtask

    task automatic test_flush();
        int lat; int sc; logic [31:0] res; logic sd; logic da;
        start_i = 1'b1; op_i = 3'd0; rs1_i = 32'd7; rs2_i = 32'd6;
        tick();                                   // edge closing cycle T
        start_i = 1'b0;
        for (int i = 0; i < 9; i++) tick();       // now in cycle T+10
        flush_i = 1'b1;
        #1;
        n_cmp++; if (stall_o !== 1'b1) begin n_err++; $display("FAIL flush_stall_in_flush_cycle: got %b want 1", stall_o); end
        tick();                                   // cycle T+11
        flush_i = 1'b0;
        #1;
        n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL flush_busy_after: got %b want 0", busy_o); end
        n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL flush_stall_after: got %b want 0", stall_o); end
        n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL flush_done_t11: got %b want 0", done_o); end
        tick();                                   // cycle T+12
        n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL flush_done_t12: got %b want 0", done_o); end
        run_op(3'd0, 32'd3, 32'd5, lat, res, sc, sd, da);
        n_cmp++; if (res !== 32'd15) begin n_err++; $display("FAIL flush_next_result: got %h want 0000000f", res); end
        n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL flush_next_latency: got %0d want 33", lat); end
    endtask

    task automatic test_flush_in_done();
        // A flushed start in IDLE is not accepted.
        start_i = 1'b1; flush_i = 1'b1; op_i = 3'd5; rs1_i = 32'd5; rs2_i = 32'd0;
        #1;
        n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL flushed_start_stall: got %b want 0", stall_o); end
        tick();
        flush_i = 1'b0; start_i = 1'b0;
        #1;
        n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL flushed_start_busy: got %b want 0", busy_o); end
        // Flush while in DONE still shows the pulse.
        start_i = 1'b1;
        tick();
        start_i = 1'b0; flush_i = 1'b1;
        #1;
        n_cmp++; if (done_o !== 1'b1) begin n_err++; $display("FAIL flush_in_done_pulse: got %b want 1", done_o); end
        n_cmp++; if (result_o !== 32'hFFFFFFFF) begin n_err++; $display("FAIL flush_in_done_result: got %h want ffffffff", result_o); end
        tick();
        flush_i = 1'b0;
        n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL flush_in_done_after: got %b want 0", done_o); end
    endtask

    task automatic test_start_in_done();
        start_i = 1'b1; op_i = 3'd7; rs1_i = 32'h00001234; rs2_i = 32'd0;
        tick();                                   // cycle T+1: DONE, start still high
        n_cmp++; if (done_o !== 1'b1) begin n_err++; $display("FAIL start_in_done_pulse: got %b want 1", done_o); end
        n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL start_in_done_stall: got %b want 0", stall_o); end
        tick();                                   // cycle T+2
        n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL start_in_done_busy: got %b want 0", busy_o); end
        n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL start_in_done_repulse: got %b want 0", done_o); end
        start_i = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        int lat; int sc; logic [31:0] res; logic sd; logic da;
        run_op(3'd5, 32'd100, 32'd7, lat, res, sc, sd, da);
        n_cmp++; if (res !== 32'd14) begin n_err++; $display("FAIL b2b_divu_result: got %h want 0000000e", res); end
        n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL b2b_divu_latency: got %0d want 33", lat); end
        run_op(3'd7, 32'd100, 32'd7, lat, res, sc, sd, da);
        n_cmp++; if (res !== 32'd2) begin n_err++; $display("FAIL b2b_remu_result: got %h want 00000002", res); end
        n_cmp++; if (lat !== PAIR_LAT) begin n_err++; $display("FAIL b2b_remu_latency: got %0d want %0d", lat, PAIR_LAT); end
        run_op(3'd1, 32'h00010000, 32'h00010000, lat, res, sc, sd, da);
        n_cmp++; if (res !== 32'd1) begin n_err++; $display("FAIL b2b_mulh_result: got %h want 00000001", res); end
        run_op(3'd0, 32'h00010000, 32'h00010000, lat, res, sc, sd, da);
        n_cmp++; if (res !== 32'd0) begin n_err++; $display("FAIL b2b_mul_result: got %h want 00000000", res); end
        n_cmp++; if (lat !== PAIR_LAT) begin n_err++; $display("FAIL b2b_mul_latency: got %0d want %0d", lat, PAIR_LAT); end
    endtask

    task automatic test_reset_mid_op();
        int dcount; int lat; int sc; logic [31:0] res; logic sd; logic da;
        start_i = 1'b1; op_i = 3'd5; rs1_i = 32'd100; rs2_i = 32'd9;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        n_cmp++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL mid_op_busy: got %b want 1", busy_o); end
        reset_n = 1'b0;
        tick();
        n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL mid_reset_busy: got %b want 0", busy_o); end
        n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL mid_reset_stall: got %b want 0", stall_o); end
        n_cmp++; if (result_o !== 32'd0) begin n_err++; $display("FAIL mid_reset_result: got %h want 0", result_o); end
        reset_n = 1'b1;
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done_o === 1'b1) dcount++;
        end
        n_cmp++; if (dcount !== 0) begin n_err++; $display("FAIL mid_reset_no_done: got %0d pulses want 0", dcount); end
        // Reset also drops any remembered result pair.
        run_op(3'd7, 32'd100, 32'd7, lat, res, sc, sd, da);
        n_cmp++; if (res !== 32'd2) begin n_err++; $display("FAIL post_reset_remu_result: got %h want 00000002", res); end
        n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL post_reset_remu_latency: got %0d want 33", lat); end
    endtask

    initial begin
        test_reset();
        test_mulhu();
        test_mul_signed();
        test_div();
        test_div_special();
        test_flush();
        test_flush_in_done();
        test_start_in_done();
        test_back_to_back();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ex_muldiv_seq.md
Name: ex_muldiv_seq

Overview:
Iterative sequencer for RV32M multiply/divide ops presented in the EX stage. It latches operands when an M-op enters EX and runs a shift-add multiplier or restoring divider for DATA_W cycles. While the op runs it stalls the upstream pipeline. It delivers a one-cycle result the EX/MEM register captures in place of the ALU result, and aborts cleanly on a pipeline flush.

Parameters:
DATA_W, 32, operand/result width; iteration count equals DATA_W
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W

Ports:
clk  in  1  clock
reset_n  in  1  reset
start_i  in  1  valid M-extension op currently in EX
op_i  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
rs1_i  in  DATA_W  forwarded operand 1
rs2_i  in  DATA_W  forwarded operand 2
flush_i  in  1  EX instruction squashed (taken branch/trap)
stall_o  out  1  hold PC, IF/ID, ID/EX; suppress EX/MEM update
busy_o  out  1  state != IDLE
done_o  out  1  result valid this cycle (one-cycle pulse)
result_o  out  DATA_W  result; held stable while done_o=1

Behaviour:
- Reset: reset_n is synchronous, active-low, on clk. All regs clear, state=IDLE. Outputs: stall_o=0, busy_o=0, done_o=0, result_o=0. Reset mid-operation returns to IDLE, with no done_o.
- States: IDLE, CALC, DONE.
- IDLE: if start_i && !flush_i, latch op, magnitudes of rs1/rs2 and the result-negate flag.
  - Divide-by-zero (rs2=0, op 4-7) or signed overflow (DIV/REM with rs1=0x80000000, rs2=0xFFFFFFFF): preload special result and go to DONE.
  - Otherwise go to CALC with cnt=0.
- stall_o = (IDLE && start_i && !flush_i) || CALC. It is combinational so the issuing cycle stalls. stall_o=0 in DONE.
- CALC: one iteration per cycle; cnt increments.
  - Multiply: 2*DATA_W product register, shift-add on multiplier LSB.
  - Divide: restoring; shift remainder left, trial-subtract divisor, set quotient bit.
  - After iteration DATA_W-1 go to DONE.
- DONE: done_o=1, result_o valid. Next state is IDLE unconditionally; start_i is ignored (the same instruction advances out of EX this cycle).
- Latency: start sampled at cycle T gives DONE at T+DATA_W+1, with stall_o high T..T+DATA_W. Special cases give DONE at T+1, with stall_o high at T only.
- Signedness:
  - MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - DIV/REM: signed.
  - Magnitudes are computed on entry. The final result is two's-complement negated in the CALC→DONE transition when the negate flag is set.
  - Quotient sign = sign1 XOR sign2. Remainder sign = sign of rs1.
- Result select:
  - MUL: product[DATA_W-1:0]. MULH/MULHSU/MULHU: product[2*DATA_W-1:DATA_W].
  - DIV/DIVU: quotient. REM/REMU: remainder.
- Special results:
  - Divide-by-zero: quotient=all ones, remainder=rs1.
  - Overflow: quotient=0x80000000, remainder=0.
- flush_i in CALC: go to IDLE next cycle, no done_o, stall_o drops in the flush cycle's successor. flush_i in DONE: done_o still pulses (the consumer discards it).
- Operand changes on rs1_i/rs2_i after latch have no effect.

Optional Feature:
- Macro: EX_MULDIV_PAIR_CACHE_EN.
- Enabled:
  - On every normal completion, store rs1, rs2, class (mul-signedness pair or div-signed/unsigned) plus the full 64-bit product, or both quotient and remainder.
  - A subsequent start in IDLE with identical rs1/rs2/class (e.g. DIV then REM, MULH then MUL) goes directly to DONE at T+1 with the other half selected.
  - The cache is invalidated by reset and by flush during CALC.
- Disabled: no cache storage; every op follows the normal latency.

Test Plan:
- MULHU rs1=0xFFFFFFFF rs2=0xFFFFFFFF, start at T → stall_o high T..T+32, done_o at T+33, result_o=0xFFFFFFFE.
- DIV rs1=0xFFFFFFF9 (-7) rs2=2 → result_o=0xFFFFFFFD (-3); REM same operands → 0xFFFFFFFF (-1).
- DIVU rs1=0x1234 rs2=0 → done_o at T+1, result_o=0xFFFFFFFF; REMU same → 0x00001234.
- DIV rs1=0x80000000 rs2=0xFFFFFFFF → done_o at T+1, result_o=0x80000000; REM → 0.
- MUL 7*6 started, flush_i asserted at T+10 → IDLE at T+11, no done_o, stall_o low from T+11; new MUL 3*5 at T+12 → 15 at T+45.
- With EX_MULDIV_PAIR_CACHE_EN: DIVU 100/7 → 14 at T+33; REMU 100/7 issued next → done_o one cycle after issue, result_o=2.
